wave_meas: RTL



---
 rtl/wave_meas.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/wave_meas.sv
// wave_meas: single-cycle waveform measurement on an offset-binary sample stream.
// Finds one full cycle between two rising mid-scale crossings, using hysteresis
// thresholds LO/HI, and reports the period in samples, max, min and peak-to-peak
// through a valid/ack handshake. A cycle that does not complete within
// 2^CNT_W-1 samples is reported as a timeout.
//
// Optional build macro WAVE_MEAS_AVG4_EN: one result covers four back-to-back
// cycles. The reported period is the truncated mean of the four cycles, and
// vmax/vmin cover all four cycles.
module wave_meas #(
    parameter int DW    = 14,
    parameter int HYST  = 64,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sample_valid,
    input  logic [DW-1:0]    sample,
    output logic             meas_valid,
    input  logic             meas_ack,
    output logic [CNT_W-1:0] period,
    output logic [DW-1:0]    vmax,
    output logic [DW-1:0]    vmin,
    output logic [DW-1:0]    pk2pk,
    output logic             timeout
);

    localparam int               MID     = 1 << (DW - 1);
    localparam logic [DW-1:0]    LO      = DW'(MID - HYST);
    localparam logic [DW-1:0]    HI      = DW'(MID + HYST);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_RISE,
        S_MEAS_LOW,
        S_MEAS_HIGH,
        S_REPORT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    vmax_t, vmin_t;
    logic [CNT_W-1:0] result_period;

    // Decoded per-cycle events shared by the FSM and the datapath.
    logic is_lo, is_hi, cnt_sat;
    logic clr_cnt, do_inc, do_start, do_track, do_end, do_tmo;

`ifdef WAVE_MEAS_AVG4_EN
    logic [CNT_W+1:0] sum, sum_nxt;
    logic [1:0]       cyc;
    logic             do_chain;
`endif

    assign is_lo      = (sample <= LO);
    assign is_hi      = (sample >= HI);
    assign cnt_sat    = (cnt == CNT_MAX);
    assign meas_valid = (state == S_REPORT);

    // Period to latch at the final end crossing: this cycle's count, or the
    // truncated mean of the four accumulated cycles.
`ifdef WAVE_MEAS_AVG4_EN
    assign sum_nxt       = sum + (CNT_W+2)'(cnt) + (CNT_W+2)'(1);
    assign result_period = sum_nxt[CNT_W+1:2];
`else
    assign result_period = cnt + 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for every register, so all flops
        // update from the same pre-edge values regardless of block ordering.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and datapath strobes; timeout wins over a crossing,
    // and en=0 wins over everything except an open handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt = state;
        clr_cnt   = 1'b0;
        do_inc    = 1'b0;
        do_start  = 1'b0;
        do_track  = 1'b0;
        do_end    = 1'b0;
        do_tmo    = 1'b0;
`ifdef WAVE_MEAS_AVG4_EN
        do_chain  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (en) state_nxt = S_ARM;
            end
            S_ARM: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (sample_valid && is_lo) begin
                    clr_cnt   = 1'b1;
                    state_nxt = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (cnt_sat) begin
                    do_tmo    = 1'b1;
                    state_nxt = S_REPORT;
                end else if (sample_valid) begin
                    if (is_hi) begin
                        clr_cnt   = 1'b1;
                        do_start  = 1'b1;
                        state_nxt = S_MEAS_LOW;
                    end else begin
                        do_inc = 1'b1;
                    end
                end
            end
            S_MEAS_LOW: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (cnt_sat) begin
                    do_tmo    = 1'b1;
                    state_nxt = S_REPORT;
                end else if (sample_valid) begin
                    do_inc   = 1'b1;
                    do_track = 1'b1;
                    if (is_lo) state_nxt = S_MEAS_HIGH;
                end
            end
            S_MEAS_HIGH: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (cnt_sat) begin
                    do_tmo    = 1'b1;
                    state_nxt = S_REPORT;
                end else if (sample_valid) begin
                    if (is_hi) begin
`ifdef WAVE_MEAS_AVG4_EN
                        if (cyc == 2'd3) begin
                            do_end    = 1'b1;
                            state_nxt = S_REPORT;
                        end else begin
                            // End of this cycle doubles as start of the next.
                            do_chain  = 1'b1;
                            clr_cnt   = 1'b1;
                            do_track  = 1'b1;
                            state_nxt = S_MEAS_LOW;
                        end
`else
                        do_end    = 1'b1;
                        state_nxt = S_REPORT;
`endif
                    end else begin
                        do_inc   = 1'b1;
                        do_track = 1'b1;
                    end
                end
            end
            S_REPORT: begin
                if (meas_ack) state_nxt = en ? S_ARM : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sample counter, min/max trackers and the latched result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            vmax_t  <= '0;
            vmin_t  <= '0;
            period  <= '0;
            vmax    <= '0;
            vmin    <= '0;
            pk2pk   <= '0;
            timeout <= 1'b0;
`ifdef WAVE_MEAS_AVG4_EN
            sum     <= '0;
            cyc     <= '0;
`endif
        end else begin
            // Increment is only requested below CNT_MAX, so cnt never wraps.
            if (clr_cnt)     cnt <= '0;
            else if (do_inc) cnt <= cnt + 1'b1;

            if (do_start) begin
                vmax_t <= sample;
                vmin_t <= sample;
            end else if (do_track) begin
                if (sample > vmax_t) vmax_t <= sample;
                if (sample < vmin_t) vmin_t <= sample;
            end

`ifdef WAVE_MEAS_AVG4_EN
            if (do_start) begin
                sum <= '0;
                cyc <= '0;
            end else if (do_chain) begin
                sum <= sum_nxt;
                cyc <= cyc + 2'd1;
            end
`endif

            if (do_end) begin
                period  <= result_period;
                vmax    <= vmax_t;
                vmin    <= vmin_t;
                pk2pk   <= vmax_t - vmin_t;
                timeout <= 1'b0;
            end else if (do_tmo) begin
                period  <= '0;
                vmax    <= '0;
                vmin    <= '0;
                pk2pk   <= '0;
                timeout <= 1'b1;
            end
        end
    end

endmodule
